// File: rtl/rv_pkg.sv
// Shared RV64 execute-stage definitions: operand width, M-extension divide op
// encodings, special-case result constants and the divider state encoding.
package rv_pkg;
    localparam int XLEN = 64;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN64  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Combinational, zero latency; no flow control.
module div_step
    import rv_pkg::*;
(
    input  logic [XLEN-2:0] rem_lo,
    input  logic            carry,
    input  logic            dbit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            qbit
);
    logic [XLEN-1:0] t;
    logic            lt;

    assign t = {rem_lo, dbit};

    ult_cmp #(.W(XLEN)) u_cmp (
        .a  (t),
        .b  (divisor),
        .lt (lt)
    );

    // The carry is the 65th bit of the shifted remainder, so {carry,t} >= divisor
    // whenever it is set, and the 64-bit difference is then exact.
    assign qbit     = carry | ~lt;
    assign rem_next = qbit ? (t - divisor) : t;
endmodule

// File: rtl/ult_cmp.sv
// Unsigned less-than comparator, purely combinational (zero latency, no flow control).
module ult_cmp #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt
);
    assign lt = (a < b);
endmodule

// File: rtl/riscv_div_unit.sv
// Iterative radix-2 RV64M DIV/DIVU/REM/REMU; 66 edges accept-to-valid, 1 edge for div-by-zero/overflow.
// One op in flight: in_ready only in IDLE; result is held in DONE until out_ready; flush wins everywhere.
module riscv_div_unit
    import rv_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    div_state_t      state, state_nxt;
    logic [5:0]      count;
    logic [XLEN-1:0] rem, quo, bmag;
    logic [1:0]      op;
    logic            neg_q, neg_r;

    logic            accept, in_signed, sa, sb, b_zero, ovf;
    logic [XLEN-1:0] amag, bmag_in, step_rem, fix_sel, fix_val;
    logic            step_qbit, fix_neg;

    assign accept    = in_valid & in_ready & ~flush;
    assign in_signed = ~in_op[0];
    assign sa        = in_signed & in_a[XLEN-1];
    assign sb        = in_signed & in_b[XLEN-1];
    assign amag      = sa ? (~in_a + 1'b1) : in_a;
    assign bmag_in   = sb ? (~in_b + 1'b1) : in_b;
    assign b_zero    = (in_b == '0);
    assign ovf       = in_signed & (in_a == INT_MIN64) & (in_b == DIV_ZERO_Q);

    div_step u_step (
        .rem_lo   (rem[XLEN-2:0]),
        .carry    (rem[XLEN-1]),
        .dbit     (quo[XLEN-1]),
        .divisor  (bmag),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    assign fix_sel = op[1] ? rem : quo;
    assign fix_neg = op[1] ? neg_r : neg_q;
    assign fix_val = fix_neg ? (~fix_sel + 1'b1) : fix_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) state_nxt = (b_zero | ovf) ? DONE : RUN;
                RUN:  if (count == 6'd0) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            rem        <= '0;
            quo        <= '0;
            bmag       <= '0;
            op         <= DIV_OP_DIV;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (accept) begin
            op      <= in_op;
            out_tag <= in_tag;
            neg_q   <= sa ^ sb;
            neg_r   <= sa;
            rem     <= '0;
            quo     <= amag;
            bmag    <= bmag_in;
            count   <= 6'd63;
            // Special cases bypass the iteration and complete straight into DONE.
            if (b_zero)   out_result <= in_op[1] ? in_a : DIV_ZERO_Q;
            else if (ovf) out_result <= in_op[1] ? '0 : INT_MIN64;
        end else if (!flush) begin
            if (state == RUN) begin
                rem <= step_rem;
                quo <= {quo[XLEN-2:0], step_qbit};
                if (count != 6'd0) count <= count - 6'd1;
            end else if (state == FIX) begin
                out_result <= fix_val;
            end
        end
    end
endmodule
